// File: rtl/seq_arb_pkg.sv
// seq_arb_pkg: shared FSM states, match-count limits and round-robin pick helper
package seq_arb_pkg;
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;
  // First set req bit at or after ptr, wrapping within n requesters.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
    logic [2:0] w;
    logic f;
    int idx;
    w = ptr;
    f = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = (int'(ptr) + i) % n;
      if (!f && i < n && req[idx[2:0]]) begin
        w = idx[2:0];
        f = 1'b1;
      end
    end
    return w;
  endfunction
endpackage

// File: rtl/seq_stream_arbiter_core.sv
// seq_match_core: serial PATTERN matcher with PAT_LEN-bit history and saturating seen count
// Ports: clock/reset_n (async active-low), clear (sync wipe), bit_in/bit_en (serial input),
//        match_next (combinational: accepting bit_in now completes PATTERN)
module seq_match_core #(
  parameter int PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic bit_in,
  input  logic bit_en,
  output logic match_next
);
  localparam int SW = $clog2(PAT_LEN + 1);
  logic [PAT_LEN-1:0] r_hist, w_hist;
  logic [SW-1:0] r_seen, w_seen;
  assign w_hist = {r_hist[PAT_LEN-2:0], bit_in};
  assign w_seen = (r_seen == SW'(PAT_LEN)) ? r_seen : r_seen + SW'(1);
  assign match_next = bit_en && (w_seen == SW'(PAT_LEN)) && (w_hist == PATTERN);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_hist <= '0;
      r_seen <= '0;
    end else if (clear) begin
      r_hist <= '0;
      r_seen <= '0;
    end else if (bit_en) begin
      r_hist <= w_hist;
      r_seen <= w_seen;
    end
endmodule

// File: rtl/seq_stream_arbiter.sv
// seq_stream_arbiter: packet-granular round-robin sharing of one serial pattern matcher
// Ports: i_req/i_bit_in/i_bit_valid/i_bit_last per channel; o_grant one-hot owner (= bit ready);
//        o_busy packet in progress; o_match/o_match_id match pulse; o_pkt_done/o_pkt_id/
//        o_pkt_match_cnt/o_pkt_abort per-packet summary pulse.
// Option: SEQ_ARB_TIMEOUT_EN ends a packet after TIMEOUT_CYC stalled cycles with o_pkt_abort.
module seq_stream_arbiter
  import seq_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter int MAX_PKT_BITS = 64,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [NUM_REQ-1:0]         i_bit_in,
  input  logic [NUM_REQ-1:0]         i_bit_valid,
  input  logic [NUM_REQ-1:0]         i_bit_last,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic                       o_busy,
  output logic                       o_match,
  output logic [$clog2(NUM_REQ)-1:0] o_match_id,
  output logic                       o_pkt_done,
  output logic [$clog2(NUM_REQ)-1:0] o_pkt_id,
  output logic [CNT_W-1:0]           o_pkt_match_cnt,
  output logic                       o_pkt_abort
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_PKT_BITS + 1);
  state_t r_state;
  logic [IW-1:0] r_owner, r_ptr, w_win;
  logic [BW-1:0] r_bits;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic w_acc, w_mn, w_m, w_end, w_to;
  assign w_acc = (r_state == STREAM) && |(o_grant & i_bit_valid);
  assign w_m = w_acc && w_mn;
  assign w_cnt = (w_m && r_cnt != CNT_MAX) ? r_cnt + CNT_W'(1) : r_cnt;
  assign w_end = w_acc && (i_bit_last[r_owner] || r_bits == BW'(MAX_PKT_BITS - 1));
  assign w_win = IW'(rr_pick(8'(i_req), 3'(r_ptr), NUM_REQ));
`ifdef SEQ_ARB_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYC + 1);
  logic [SW-1:0] r_stall;
  // Stall counter runs only in STREAM; an accept restarts it.
  assign w_to = (r_state == STREAM) && !w_acc && r_stall == SW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_stall <= '0;
      o_pkt_abort <= 1'b0;
    end else begin
      r_stall <= (r_state != STREAM || w_acc) ? '0 : r_stall + SW'(1);
      o_pkt_abort <= w_to;
    end
`else
  assign w_to = 1'b0;
  assign o_pkt_abort = 1'b0;
`endif
  seq_match_core #(.PAT_LEN(PAT_LEN), .PATTERN(PATTERN)) u_core (
    .clock(clock),
    .reset_n(reset_n),
    .clear(r_state == IDLE),
    .bit_in(i_bit_in[r_owner]),
    .bit_en(w_acc),
    .match_next(w_mn)
  );
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_ptr <= '0;
      r_bits <= '0;
      r_cnt <= '0;
      o_grant <= '0;
      o_busy <= 1'b0;
      o_match <= 1'b0;
      o_match_id <= '0;
      o_pkt_done <= 1'b0;
      o_pkt_id <= '0;
      o_pkt_match_cnt <= '0;
    end else begin
      o_match <= w_m;
      o_pkt_done <= 1'b0;
      if (w_m) o_match_id <= r_owner;
      case (r_state)
        IDLE:
          if (|i_req) begin
            o_grant <= NUM_REQ'(1) << w_win;
            r_owner <= w_win;
            o_busy <= 1'b1;
            r_bits <= '0;
            r_cnt <= '0;
            r_state <= STREAM;
          end
        STREAM: begin
          r_cnt <= w_cnt;
          if (w_acc) r_bits <= r_bits + BW'(1);
          if (w_end || w_to) begin
            o_grant <= '0;
            o_pkt_done <= 1'b1;
            o_pkt_id <= r_owner;
            o_pkt_match_cnt <= w_cnt;
            r_state <= DONE;
          end
        end
        DONE: begin
          o_busy <= 1'b0;
          r_ptr <= (r_owner == IW'(NUM_REQ - 1)) ? '0 : r_owner + IW'(1);
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule
